// File: rtl/led_bank_pkg.sv
// Shared constants for the LED bank controller: mode encoding and address-width helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package led_bank_pkg;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_PWM    = 2'd2;
    localparam logic [1:0] MODE_CHASE  = 2'd3;

    // Channel-index width; a single channel still gets a 1-bit address.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running divider: emits a one-cycle tick every PRESCALE clk cycles.
// Latency: tick is registered, high the cycle after the counter reaches PRESCALE-1.
// Backpressure: none; runs continuously.
// Ports: clk, rstn (sync active-low), tick (one-cycle pulse).
module led_prescaler #(
    parameter int PRESCALE = 6_000_000
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CW'(PRESCALE - 1));
            if (cnt == CW'(PRESCALE - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_bank_ctrl.sv
// N-channel LED driver: static, blink, per-channel PWM and one-hot chase modes.
// Latency: one clk from any input change to the leds pins (registered output).
// Backpressure: none; duty writes are always accepted, out-of-range addresses dropped.
// Ports: clk, rstn (sync active-low), enable, mode, pattern, wr_en/wr_addr/wr_data
//        (duty-register write port), tick (prescaler pulse), leds (pin level).
module led_bank_ctrl
    import led_bank_pkg::*;
#(
    parameter int                N_LEDS      = 5,
    parameter int                PWM_BITS    = 8,
    parameter int                PRESCALE    = 6_000_000,
    parameter logic [N_LEDS-1:0] INVERT_MASK = '0
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              enable,
    input  logic [1:0]                        mode,
    input  logic [N_LEDS-1:0]                 pattern,
    input  logic                              wr_en,
    input  logic [addr_width(N_LEDS)-1:0]     wr_addr,
    input  logic [PWM_BITS-1:0]               wr_data,
    output logic                              tick,
    output logic [N_LEDS-1:0]                 leds
);

    localparam int AW = addr_width(N_LEDS);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty [N_LEDS];
    logic                phase;
    logic [AW-1:0]       chase_pos;
    logic [1:0]          mode_q;
    logic                mode_chg;
    logic                phase_eff;
    logic [AW-1:0]       chase_eff;
    logic [N_LEDS-1:0]   on;

    led_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rstn (rstn),
        .tick (tick)
    );

    // On the mode-change cycle itself the phase/chase registers still hold
    // stale values; forcing them to zero here makes a new BLINK show its
    // on-phase and a new CHASE show channel 0 right away.
    assign mode_chg  = (mode != mode_q);
    assign phase_eff = mode_chg ? 1'b0 : phase;
    assign chase_eff = mode_chg ? '0   : chase_pos;

    always_comb begin
        on = '0;
        case (mode)
            MODE_STATIC: on = pattern;
            MODE_BLINK:  on = phase_eff ? '0 : pattern;
            MODE_PWM: begin
                for (int i = 0; i < N_LEDS; i++) begin
                    on[i] = (pwm_cnt < duty[i]);
                end
            end
            MODE_CHASE: begin
                for (int i = 0; i < N_LEDS; i++) begin
                    on[i] = (chase_eff == AW'(i));
                end
            end
            default: on = '0;
        endcase
        if (!enable) begin
            on = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwm_cnt   <= '0;
            phase     <= 1'b0;
            chase_pos <= '0;
            mode_q    <= MODE_STATIC;
            leds      <= INVERT_MASK;
            for (int i = 0; i < N_LEDS; i++) begin
                duty[i] <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            mode_q  <= mode;

            // Mode change outranks a coincident tick.
            if (mode_chg) begin
                phase     <= 1'b0;
                chase_pos <= '0;
            end else if (tick) begin
                phase     <= ~phase;
                chase_pos <= (chase_pos == AW'(N_LEDS - 1)) ? '0 : chase_pos + AW'(1);
            end

            // Addresses >= N_LEDS match no channel and are dropped.
            for (int i = 0; i < N_LEDS; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    duty[i] <= wr_data;
                end
            end

            leds <= on ^ INVERT_MASK;
        end
    end

endmodule

// File: tb/tb_led_bank_ctrl.sv
module tb_led_bank_ctrl;

    localparam int N    = 5;
    localparam int PB   = 4;
    localparam int PS   = 4;
    localparam logic [N-1:0] INV = 5'b01111;

    logic          clk = 1'b0;
    logic          rstn;
    logic          enable;
    logic [1:0]    mode;
    logic [N-1:0]  pattern;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [PB-1:0] wr_data;
    logic          tick;
    logic          tick_inv;
    logic [N-1:0]  leds;
    logic [N-1:0]  leds_inv;

    int checks = 0;
    int fails  = 0;
    int cnt [N];

    always #5 clk = ~clk;

    led_bank_ctrl #(
        .N_LEDS(N), .PWM_BITS(PB), .PRESCALE(PS), .INVERT_MASK(5'b00000)
    ) u_dut (
        .clk(clk), .rstn(rstn), .enable(enable), .mode(mode), .pattern(pattern),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .tick(tick), .leds(leds)
    );

    led_bank_ctrl #(
        .N_LEDS(N), .PWM_BITS(PB), .PRESCALE(PS), .INVERT_MASK(INV)
    ) u_inv (
        .clk(clk), .rstn(rstn), .enable(enable), .mode(mode), .pattern(pattern),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .tick(tick_inv), .leds(leds_inv)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until tick is seen high (bounded); leaves time at a tick cycle.
    task automatic sync_tick(input logic [N-1:0] hold_leds);
        for (int k = 0; k < 8 && tick !== 1'b1; k++) begin
            step();
            if (tick !== 1'b1) check("pre_tick_leds", leds, hold_leds);
        end
        check("tick_sync", tick, 1'b1);
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b1; mode = 2'd0; pattern = 5'b10110;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // 1: reset then STATIC
        step(); step(); step();
        check("rst_leds", leds, 5'b00000);
        check("rst_leds_inv", leds_inv, INV);
        check("rst_tick", tick, 1'b0);
        rstn = 1'b1;
        step();
        check("static_leds", leds, 5'b10110);
        check("static_leds_inv", leds_inv, 5'b11001);

        // 2: BLINK, period 4 per phase
        mode = 2'd1; pattern = 5'b11111;
        step();
        check("blink_start", leds, 5'b11111);
        sync_tick(5'b11111);
        check("blink_at_tick", leds, 5'b11111);
        for (int j = 1; j <= 16; j++) begin
            step();
            check("blink_leds", leds, (((j + 2) / 4) % 2 == 0) ? 5'b11111 : 5'b00000);
            check("blink_tick", tick, (j % 4 == 0) ? 1'b1 : 1'b0);
        end

        // 3: PWM duties 0/4/15, out-of-range write ignored
        mode = 2'd2;
        wr_en = 1'b1;
        wr_addr = 3'd0; wr_data = 4'd0;  step();
        wr_addr = 3'd1; wr_data = 4'd4;  step();
        wr_addr = 3'd2; wr_data = 4'd15; step();
        wr_addr = 3'd7; wr_data = 4'd9;  step();
        wr_en = 1'b0;
        step();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int j = 0; j < 16; j++) begin
            step();
            for (int i = 0; i < N; i++) cnt[i] += int'(leds[i]);
        end
        check("pwm_cnt0", cnt[0], 0);
        check("pwm_cnt1", cnt[1], 4);
        check("pwm_cnt2", cnt[2], 15);
        check("pwm_cnt3", cnt[3], 0);
        check("pwm_cnt4", cnt[4], 0);

        // 4: CHASE walks one step per tick, wraps, restarts after mode change
        mode = 2'd3;
        step();
        check("chase_start", leds, 5'b00001);
        sync_tick(5'b00001);
        for (int j = 1; j <= 24; j++) begin
            logic [N-1:0] exp_oh;
            exp_oh = 5'b00001 << (((j + 2) / 4) % 5);
            step();
            check("chase_leds", leds, exp_oh);
        end
        mode = 2'd0; pattern = 5'b10110;
        step();
        check("chase_to_static", leds, 5'b10110);
        mode = 2'd3;
        step();
        check("chase_restart", leds, 5'b00001);
        step();
        check("chase_restart2", leds, 5'b00001);

        // 5: enable=0 forces off in every mode; inverted instance shows mask
        pattern = 5'b11111;
        enable = 1'b0;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            step();
            check("dis_leds", leds, 5'b00000);
            check("dis_leds_inv", leds_inv, INV);
        end
        enable = 1'b1;
        mode = 2'd0;
        step();
        check("reen_leds_inv", leds_inv, 5'b11111 ^ INV);

        // 6: reset mid-PWM with concurrent write clears all duties
        mode = 2'd2;
        step(); step();
        rstn = 1'b0; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'd10;
        step();
        check("rst2_leds", leds, 5'b00000);
        rstn = 1'b1; wr_en = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int j = 0; j < 16; j++) begin
            step();
            for (int i = 0; i < N; i++) cnt[i] += int'(leds[i]);
        end
        check("rst2_cnt1", cnt[1], 0);
        check("rst2_cnt2", cnt[2], 0);
        check("rst2_leds_inv", leds_inv, INV);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
